// File: rtl/somador_sequencial.sv
// Sequential slice-serial adder/subtractor. Adds FATIA bits per clock,
// LSB slice first, and publishes Soma/Cout/Overflow only on completion.
module somador_sequencial #(
  parameter int LARGURA = 16,
  parameter int FATIA   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic               sub,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic               Cin,
  output logic [LARGURA-1:0] Soma,
  output logic               Cout,
  output logic               Overflow,
  output logic               ocupado,
  output logic               pronto
);

  localparam int NFAT = LARGURA / FATIA;
  localparam int CW   = (NFAT > 1) ? $clog2(NFAT) : 1;

  localparam logic [0:0]    OCIOSO  = 1'b0;
  localparam logic [0:0]    SOMANDO = 1'b1;
  localparam logic [CW-1:0] ULTIMA  = CW'(NFAT - 1);

  // State and datapath registers
  logic [0:0]         estado_q, estado_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LARGURA-1:0] a_q, a_d;       // operand A, shifted right one slice per step
  logic [LARGURA-1:0] b_q, b_d;       // conditionally inverted B, shifted likewise
  logic               carry_q, carry_d;
  logic [LARGURA-1:0] parc_q, parc_d; // partial result, filled from the top down
  logic [LARGURA-1:0] soma_q, soma_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               pronto_q, pronto_d;

  // Slice datapath: the current slice always sits in the low FATIA bits
  logic [FATIA-1:0]   a_sl, b_sl;
  logic [FATIA:0]     fsum;
  logic [LARGURA-1:0] parc_nxt;
  logic               c_msb;

  assign a_sl     = a_q[FATIA-1:0];
  assign b_sl     = b_q[FATIA-1:0];
  assign fsum     = {1'b0, a_sl} + {1'b0, b_sl} + {{FATIA{1'b0}}, carry_q};
  // New slice enters at the top; after NFAT steps slice 0 has reached bit 0.
  assign parc_nxt = LARGURA'({fsum[FATIA-1:0], parc_q} >> FATIA);
  // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last slice.
  assign c_msb    = a_sl[FATIA-1] ^ b_sl[FATIA-1] ^ fsum[FATIA-1];

  // Next-state logic: sample operands in OCIOSO, one slice per cycle in SOMANDO
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    parc_d   = parc_q;
    soma_d   = soma_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    pronto_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          // The mode is folded into the inverted operand and carry, so it
          // needs no register of its own once sampled.
          a_d      = A;
          b_d      = B ^ {LARGURA{sub}};
          carry_d  = Cin ^ sub;
          cnt_d    = '0;
          parc_d   = '0;
          estado_d = SOMANDO;
        end
      end
      default: begin
        a_d     = a_q >> FATIA;
        b_d     = b_q >> FATIA;
        carry_d = fsum[FATIA];
        parc_d  = parc_nxt;
        if (cnt_q == ULTIMA) begin
          soma_d   = parc_nxt;
          cout_d   = fsum[FATIA];
          ovf_d    = c_msb ^ fsum[FATIA];
          pronto_d = 1'b1;
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Register update with asynchronous clear of every flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      parc_q   <= '0;
      soma_q   <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      parc_q   <= parc_d;
      soma_q   <= soma_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      pronto_q <= pronto_d;
    end
  end

  assign Soma     = soma_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
  assign pronto   = pronto_q;
  assign ocupado  = (estado_q == SOMANDO);

endmodule

// File: tb/tb_somador_sequencial.sv
// Bench for somador_sequencial: a 16/4 instance and an 8/8 instance,
// checked against a plain-arithmetic reference model.
module tb_somador_sequencial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        inicio, sub, Cin;
  logic [15:0] A, B, Soma;
  logic        Cout, Overflow, ocupado, pronto;

  logic        inicio8, sub8, cin8;
  logic [7:0]  a8, b8, soma8;
  logic        cout8, ovf8, ocup8, pronto8;

  int n_cmp = 0;
  int n_err = 0;

  somador_sequencial #(.LARGURA(16), .FATIA(4)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .sub(sub), .A(A), .B(B), .Cin(Cin),
    .Soma(Soma), .Cout(Cout), .Overflow(Overflow), .ocupado(ocupado), .pronto(pronto));

  somador_sequencial #(.LARGURA(8), .FATIA(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .Soma(soma8), .Cout(cout8), .Overflow(ovf8), .ocupado(ocup8), .pronto(pronto8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, carry, sum} of A + (sub ? ~B : B) + (Cin ^ sub) at width w
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic s);
    longint mask, aa, bb, full, res;
    logic   co, ov;
    mask = (longint'(1) << w) - 1;
    aa   = longint'(a) & mask;
    bb   = s ? (~longint'(b) & mask) : (longint'(b) & mask);
    full = aa + bb + longint'(cin ^ s);
    res  = full & mask;
    co   = ((full >> w) & 1) != 0;
    ov   = (((aa >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
           (((res >> (w-1)) & 1) != ((aa >> (w-1)) & 1));
    return {ov, co, res[15:0]};
  endfunction

  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic ts);
    logic [17:0] e;
    logic [15:0] prev;
    int lat;
    bit seen;
    e = ref_op(16, ta, tb_, tc, ts);
    @(negedge clk);
    prev = Soma;
    A = ta; B = tb_; Cin = tc; sub = ts; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    chk({tag, ".ocupado"}, 32'(ocupado), 32'd1);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      // Scrambled inputs mid-operation must not leak into the result
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
      if (pronto) seen = 1;
      else chk({tag, ".hold"}, 32'(Soma), 32'(prev));
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".soma"}, 32'(Soma), 32'(e[15:0]));
    chk({tag, ".cout"}, 32'(Cout), 32'(e[16]));
    chk({tag, ".ovf"}, 32'(Overflow), 32'(e[17]));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(pronto), 32'd0);
    chk({tag, ".idle"}, 32'(ocupado), 32'd0);
    chk({tag, ".keep"}, 32'(Soma), 32'(e[15:0]));
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input logic ts);
    logic [17:0] e;
    int lat;
    bit seen;
    e = ref_op(8, {8'h00, ta}, {8'h00, tb_}, tc, ts);
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts; inicio8 = 1'b1;
    @(posedge clk); #1;
    inicio8 = 1'b0;
    chk({tag, ".ocupado"}, 32'(ocup8), 32'd1);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (pronto8) seen = 1;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd1);
    chk({tag, ".soma"}, 32'(soma8), 32'(e[7:0]));
    chk({tag, ".cout"}, 32'(cout8), 32'(e[16]));
    chk({tag, ".ovf"}, 32'(ovf8), 32'(e[17]));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(pronto8), 32'd0);
  endtask

  initial begin
    int npr;
    rst_n = 1'b0;
    inicio = 0; sub = 0; Cin = 0; A = '0; B = '0;
    inicio8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.soma", 32'(Soma), 32'd0);
    chk("rst.cout", 32'(Cout), 32'd0);
    chk("rst.ovf", 32'(Overflow), 32'd0);
    chk("rst.ocupado", 32'(ocupado), 32'd0);
    chk("rst.pronto", 32'(pronto), 32'd0);
    chk("rst.soma8", 32'(soma8), 32'd0);
    rst_n = 1'b1;

    // First edge after release takes the request
    run16("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("carry_wrap.exact_soma", 32'(Soma), 32'h0000);
    chk("carry_wrap.exact_cout", 32'(Cout), 32'd1);
    run16("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("pos_ovf.exact_soma", 32'(Soma), 32'h8000);
    chk("pos_ovf.exact_ovf", 32'(Overflow), 32'd1);
    run16("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
    chk("sub_neg.exact_soma", 32'(Soma), 32'hFFFE);
    run16("sub_borrow", 16'h0009, 16'h0003, 1'b1, 1'b1);
    chk("sub_borrow.exact_soma", 32'(Soma), 32'h0005);
    chk("sub_borrow.exact_cout", 32'(Cout), 32'd1);

    // A start request while busy is dropped
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; Cin = 0; sub = 0; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    A = 16'hAAAA; B = 16'h5555; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    npr = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pronto) npr++;
    end
    chk("ignore.npronto", 32'(npr), 32'd1);
    chk("ignore.soma", 32'(Soma), 32'h2345);

    // Reset mid-operation aborts it
    @(negedge clk);
    A = 16'h0F0F; B = 16'h0101; Cin = 0; sub = 0; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.soma", 32'(Soma), 32'd0);
    chk("abort.ocupado", 32'(ocupado), 32'd0);
    chk("abort.pronto", 32'(pronto), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    npr = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (pronto) npr++;
    end
    chk("abort.npronto", 32'(npr), 32'd0);
    chk("abort.soma_after", 32'(Soma), 32'd0);
    chk("abort.cout_after", 32'(Cout), 32'd0);
    run16("after_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    chk("after_abort.exact_soma", 32'(Soma), 32'h1010);

    for (int i = 0; i < 12; i++)
      run16($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    run8("w8", 8'h80, 8'h80, 1'b1, 1'b0);
    chk("w8.exact_soma", 32'(soma8), 32'h01);
    chk("w8.exact_cout", 32'(cout8), 32'd1);
    chk("w8.exact_ovf", 32'(ovf8), 32'd1);
    for (int i = 0; i < 4; i++)
      run8($sformatf("rnd8_%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
